// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative unsigned multiply/divide unit, one bit per cycle
// Shift-add multiply and restoring divide; result leaves as a one-cycle write-back.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [4:0]       dest_addr,
  output logic             busy,
  output logic             done,
  output logic             wb_en,
  output logic [4:0]       wb_addr,
  output logic [WIDTH-1:0] wb_data
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, WB} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      count_q;
  logic [1:0]         op_q;
  logic [4:0]         dest_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   last_q;
  logic [WIDTH-1:0]   result;
  logic               div_zero;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_diff;
  logic               rem_ge;

  assign div_zero = op[1] && (operand_b == '0);

  // opnd_q holds the multiplicand for MUL/MULH and the divisor for DIVU/REMU
  assign mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign rem_diff  = rem_shift - {1'b0, opnd_q};
  // remainder stays below the divisor, so a borrow out of bit WIDTH means "less than"
  assign rem_ge    = ~rem_diff[WIDTH];

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = div_zero ? WB : RUN;
      RUN:     if (count_q == CW'(1)) state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      op_q    <= '0;
      dest_q  <= '0;
      opnd_q  <= '0;
      prod_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      last_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          op_q    <= op;
          dest_q  <= dest_addr;
          count_q <= CW'(WIDTH);
          if (op[1]) begin
            opnd_q <= operand_b;
            // divide-by-zero results are preloaded so WB selects them like any other
            quo_q  <= div_zero ? '1 : operand_a;
            rem_q  <= div_zero ? operand_a : '0;
          end else begin
            opnd_q <= operand_a;
            prod_q <= {{WIDTH{1'b0}}, operand_b};
          end
        end
        RUN: begin
          count_q <= count_q - 1'b1;
          if (op_q[1]) begin
            rem_q <= rem_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], rem_ge};
          end else begin
            prod_q <= {mul_sum, prod_q[WIDTH-1:1]};
          end
        end
        WB: last_q <= result;
        default: ;
      endcase
    end
  end

  always_comb begin
    result = '0;
    case (op_q)
      2'b00:   result = prod_q[WIDTH-1:0];
      2'b01:   result = prod_q[2*WIDTH-1:WIDTH];
      2'b10:   result = quo_q;
      default: result = rem_q;
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == WB);
  assign wb_en   = done && (dest_q != 5'd0);
  assign wb_addr = dest_q;
  assign wb_data = done ? result : last_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
// Directed cases followed by random operations against an arithmetic reference.
module tb_muldiv_unit;
  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [4:0]  dest_addr;
  logic        busy;
  logic        done;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int nvec  = 0;
  int nfail = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .dest_addr(dest_addr),
    .busy(busy), .done(done), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (o)
      2'd0:    return p[31:0];
      2'd1:    return p[63:32];
      2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Starts one operation, scrambles the inputs after the start cycle, and checks the write-back.
  // Returns at the negedge of the done cycle.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] d, input bit poke);
    int cyc;
    int exp_cyc;
    exp_cyc = (o[1] && b == 0) ? 1 : 33;
    @(negedge clock);
    start = 1'b1; op = o; operand_a = a; operand_b = b; dest_addr = d;
    @(negedge clock);
    start = 1'b0;
    op = 2'($urandom); operand_a = $urandom; operand_b = $urandom; dest_addr = 5'($urandom);
    cyc = 1;
    while (cyc < 40) begin
      start = poke && (cyc == 5 || cyc == 33);
      if (done) break;
      check({tag, "_busy_run"}, 32'(busy), 32'd1);
      @(negedge clock);
      cyc++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_cycle"}, cyc, exp_cyc);
    check({tag, "_busy_wb"}, 32'(busy), 32'd1);
    check({tag, "_data"}, wb_data, model(o, a, b));
    check({tag, "_wb_en"}, 32'(wb_en), 32'(d != 0));
    check({tag, "_addr"}, 32'(wb_addr), 32'(d));
  endtask

  task automatic check_idle(input string tag, input int n, input logic [31:0] held);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      start = 1'b0;
      check({tag, "_idle_busy"}, 32'(busy), 32'd0);
      check({tag, "_idle_done"}, 32'(done), 32'd0);
      check({tag, "_idle_wb_en"}, 32'(wb_en), 32'd0);
      check({tag, "_idle_hold"}, wb_data, held);
    end
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    logic [4:0]  rd;
    int          ndone;

    reset = 1'b1; start = 1'b0; op = 2'd0; operand_a = '0; operand_b = '0; dest_addr = '0;
    repeat (2) @(negedge clock);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wb_en", 32'(wb_en), 32'd0);
    check("rst_addr", 32'(wb_addr), 32'd0);
    check("rst_data", wb_data, 32'd0);
    reset = 1'b0;

    run_op("t1_mul", 2'd0, 32'd7, 32'd6, 5'd5, 1'b0);
    check_idle("t1", 2, 32'h0000_002A);

    run_op("t2_mulh", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b0);
    check("t2_mulh_const", wb_data, 32'hFFFF_FFFE);
    run_op("t2_mul", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b0);
    check("t2_mul_const", wb_data, 32'h0000_0001);

    run_op("t3_divu", 2'd2, 32'd100, 32'd7, 5'd8, 1'b0);
    check("t3_divu_const", wb_data, 32'h0000_000E);
    run_op("t3_remu", 2'd3, 32'd100, 32'd7, 5'd8, 1'b0);
    check("t3_remu_const", wb_data, 32'h0000_0002);
    run_op("t3_divbig", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 1'b0);

    run_op("t4_div0", 2'd2, 32'd9, 32'd0, 5'd4, 1'b0);
    check("t4_div0_const", wb_data, 32'hFFFF_FFFF);
    run_op("t4_rem0", 2'd3, 32'd9, 32'd0, 5'd4, 1'b0);
    check("t4_rem0_const", wb_data, 32'h0000_0009);
    check_idle("t4", 1, 32'h0000_0009);

    // Reset asserted during cycle 10 of a multiply
    @(negedge clock);
    start = 1'b1; op = 2'd0; operand_a = 32'd123; operand_b = 32'd456; dest_addr = 5'd7;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("t5_rst_busy", 32'(busy), 32'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || wb_en) ndone++;
      @(negedge clock);
    end
    check("t5_rst_no_done", ndone, 0);
    check("t5_rst_data", wb_data, 32'd0);

    run_op("t5_poke", 2'd0, 32'd1000, 32'd3000, 5'd12, 1'b1);
    check_idle("t5_poke", 3, 32'd3000000);

    run_op("t5_dest0", 2'd2, 32'd50, 32'd5, 5'd0, 1'b0);
    check("t5_dest0_wb_en", 32'(wb_en), 32'd0);

    run_op("t6_first", 2'd3, 32'd1001, 32'd10, 5'd2, 1'b0);
    run_op("t6_second", 2'd0, 32'd12345, 32'd1000, 5'd2, 1'b0);
    check_idle("t6", 1, 32'd12345000);

    for (int k = 0; k < 20; k++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 255));
        default: rb = $urandom;
      endcase
      rd = 5'($urandom_range(0, 31));
      run_op($sformatf("rnd%0d", k), ro, ra, rb, rd, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
